fp_add_pipe: RTL and testbench
==============================

// Module: fp_add_pipe
// PURPOSE
//  Pipelined, parametrised IEEE-754-style floating-point adder/subtractor for the Dijkstra_float datapath.
//  Accepts one operand pair per cycle over a valid/ready handshake; 3-stage pipeline, full backpressure.
//  Handles normalisation, special values and sign of result; carries a tag (e.g. node id) alongside.
// PARAMETERS
//  EXP_W  8   exponent field width
//  MAN_W  23  stored mantissa width (hidden 1 implicit); word width W = 1+EXP_W+MAN_W
//  TAG_W  8   sideband tag width, passed through unchanged with its operands
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block accepts operands this cycle
//  in_a       in   W      operand a
//  in_b       in   W      operand b
//  in_sub     in   1      0: a+b, 1: a-b (sign of b inverted at input)
//  in_tag     in   TAG_W  sideband tag
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_result out  W      a±b
//  out_tag    out  TAG_W  tag of the pair that produced out_result
// BEHAVIOUR
//  Reset: all stage valid bits, out_valid=0, out_result=0, out_tag=0; in_ready=1 out of reset.
//  Handshake: advance = !out_valid || out_ready; in_ready = advance; all stages shift together on advance,
//   hold otherwise. Transfer on in_valid&&in_ready / out_valid&&out_ready. Data stable while out_valid&&!out_ready.
//  Latency 3 cycles accept-to-out_valid with no stall; throughput 1/cycle; order preserved; bubbles propagate.
//  S1 align: unpack; exp==0 -> operand is zero (denormals flushed); swap so |a|>=|b| (compare exp then mant);
//   shift smaller mantissa right by exp diff into MAN_W+1 bits + guard, round, sticky; shift saturates
//   at MAN_W+3 (all bits into sticky).
//  S2 add: same effective sign -> add, else subtract (never negative after swap); result sign = sign of larger.
//  S3 normalise: carry-out -> shift right 1, exp+1; else leading-zero count, shift left, exp-lzc.
//   exp >= 2^EXP_W-1 -> ±inf; exp <= 0 -> ±0 (flush); exact cancellation -> +0.
//  Specials (precede arithmetic): any NaN -> canonical qNaN {0,all-1 exp,1,0..}; inf+(-inf) -> qNaN;
//   inf+finite -> that inf; zero+x -> x; (+0)+(-0) -> +0; (-0)+(-0) -> -0.
//  Reset mid-operation: pipeline contents discarded immediately, no result emitted for in-flight pairs.
// CONFIGURATION
//  FP_ADD_RNE_EN defined: round-to-nearest-even using guard/round/sticky in S3; rounding carry renormalises
//   (mantissa overflow -> exp+1, may produce inf).
//  FP_ADD_RNE_EN undefined: truncation (round toward zero); guard/round/sticky ignored, logic removed.
// TESTING
//  1.0+2.0: 0x3F800000,0x40000000,sub=0,tag=5 -> 0x40400000, tag 5, 3 cycles later.
//  1.0-1.0: 0x3F800000,0x3F800000,sub=1 -> 0x00000000 (+0); 2.0-3.0 -> 0xBF800000.
//  Overflow/specials: 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000; 0x7F800000+0xFF800000 -> 0x7FC00000;
//   0x7FC00001+0x3F800000 -> 0x7FC00000.
//  Rounding: 0x3F800000+0x33C00000 -> 0x3F800001 with FP_ADD_RNE_EN, 0x3F800000 without;
//   0x3F800000+0x33800000 (tie) -> 0x3F800000 both.
//  Backpressure: stream 6 pairs (tags 0..5), out_ready=0 cycles 2-6 -> in_ready drops, all 6 results
//   exactly once, in tag order, values unchanged while held.
//  Reset: pull rst_n low with 3 pairs in flight -> out_valid=0 immediately, no stale results after release.

Source files
------------

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined floating-point adder/subtractor with tag sideband.
// Define FP_ADD_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_sub,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [TAG_W-1:0]     out_tag
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int SW  = MAN_W + 4;
    localparam int XW  = SW - 1;
    localparam int EW2 = EXP_W + 2;
    localparam int MW2 = MAN_W + 2;
    localparam int LZW = $clog2(SW + 1);
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic             sa, sb, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, swap;
    logic [EXP_W-1:0] ea, eb, el, es, diff, sh;
    logic [MAN_W-1:0] fa, fb, fl, fs;
    logic [2*XW-1:0]  wide;
    logic             s1_spec_d, s1_sign_d, s1_sub_d;
    logic [W-1:0]     s1_sval_d;
    logic [SW-1:0]    s1_ml_d, s1_ms_d;

    always_comb begin
        sa     = in_a[W-1];
        ea     = in_a[MAN_W +: EXP_W];
        fa     = in_a[MAN_W-1:0];
        sb     = in_b[W-1] ^ in_sub;
        eb     = in_b[MAN_W +: EXP_W];
        fb     = in_b[MAN_W-1:0];
        nan_a  = (ea == EMAX) && (fa != '0);
        nan_b  = (eb == EMAX) && (fb != '0);
        inf_a  = (ea == EMAX) && (fa == '0);
        inf_b  = (eb == EMAX) && (fb == '0);
        zero_a = (ea == '0);
        zero_b = (eb == '0);
        s1_spec_d = 1'b1;
        s1_sval_d = '0;
        if (nan_a || nan_b)
            s1_sval_d = QNAN;
        else if (inf_a && inf_b)
            s1_sval_d = (sa != sb) ? QNAN : {sa, EMAX, {MAN_W{1'b0}}};
        else if (inf_a)
            s1_sval_d = {sa, EMAX, {MAN_W{1'b0}}};
        else if (inf_b)
            s1_sval_d = {sb, EMAX, {MAN_W{1'b0}}};
        else if (zero_a && zero_b)
            s1_sval_d = {sa & sb, {(W-1){1'b0}}};
        else if (zero_a)
            s1_sval_d = {sb, in_b[W-2:0]};
        else if (zero_b)
            s1_sval_d = in_a;
        else
            s1_spec_d = 1'b0;
        // Larger magnitude always goes on the left so S2 never goes negative.
        swap      = {ea, fa} < {eb, fb};
        el        = swap ? eb : ea;
        es        = swap ? ea : eb;
        fl        = swap ? fb : fa;
        fs        = swap ? fa : fb;
        s1_sign_d = swap ? sb : sa;
        s1_sub_d  = sa ^ sb;
        diff      = el - es;
        sh        = (diff >= EXP_W'(XW)) ? EXP_W'(XW) : diff;
        wide      = {1'b1, fs, 2'b00, {XW{1'b0}}} >> sh;
        s1_ms_d   = {wide[2*XW-1:XW], |wide[XW-1:0]};
        s1_ml_d   = {1'b1, fl, 3'b000};
    end

    logic             s1_v_q, s1_spec_q, s1_sign_q, s1_sub_q;
    logic [W-1:0]     s1_sval_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0]    s1_ml_q, s1_ms_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic [SW:0]      s2_sum_d;
    logic             s2_v_q, s2_spec_q, s2_sign_q;
    logic [W-1:0]     s2_sval_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW:0]      s2_sum_q;
    logic [TAG_W-1:0] s2_tag_q;

    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_ml_q} - {1'b0, s1_ms_q})
                               : ({1'b0, s1_ml_q} + {1'b0, s1_ms_q});

    logic [LZW-1:0]   lzc;
    logic [SW-1:0]    norm;
    logic [EW2-1:0]   exp_n, exp_r;
    logic [MW2-1:0]   mant_r;
    logic [MAN_W-1:0] frac;
    logic             inc, ovf, unf;
    logic [W-1:0]     res_d;

    always_comb begin
        lzc = LZW'(SW);
        for (int i = 0; i < SW; i++)
            if (s2_sum_q[i]) lzc = LZW'(SW - 1 - i);
        if (s2_sum_q[SW]) begin
            norm  = {s2_sum_q[SW:2], |s2_sum_q[1:0]};
            exp_n = {2'b00, s2_exp_q} + EW2'(1);
        end else begin
            norm  = s2_sum_q[SW-1:0] << lzc;
            exp_n = {2'b00, s2_exp_q} - EW2'(lzc);
        end
`ifdef FP_ADD_RNE_EN
        inc = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
        inc = 1'b0;
`endif
        mant_r = {1'b0, norm[SW-1:3]} + MW2'(inc);
        exp_r  = mant_r[MAN_W+1] ? exp_n + EW2'(1) : exp_n;
        frac   = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        ovf    = !exp_r[EW2-1] && (exp_r[EXP_W:0] >= {1'b0, EMAX});
        unf    = exp_r[EW2-1] || (exp_r == '0);
        if (s2_spec_q)
            res_d = s2_sval_q;
        else if (norm == '0)
            res_d = '0;
        else if (ovf)
            res_d = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
        else if (unf)
            res_d = {s2_sign_q, {(W-1){1'b0}}};
        else
            res_d = {s2_sign_q, exp_r[EXP_W-1:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_spec_q  <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_sval_q  <= '0;
            s1_exp_q   <= '0;
            s1_ml_q    <= '0;
            s1_ms_q    <= '0;
            s1_tag_q   <= '0;
            s2_v_q     <= 1'b0;
            s2_spec_q  <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_sval_q  <= '0;
            s2_exp_q   <= '0;
            s2_sum_q   <= '0;
            s2_tag_q   <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (advance) begin
            s1_v_q     <= in_valid;
            s1_spec_q  <= s1_spec_d;
            s1_sign_q  <= s1_sign_d;
            s1_sub_q   <= s1_sub_d;
            s1_sval_q  <= s1_sval_d;
            s1_exp_q   <= el;
            s1_ml_q    <= s1_ml_d;
            s1_ms_q    <= s1_ms_d;
            s1_tag_q   <= in_tag;
            s2_v_q     <= s1_v_q;
            s2_spec_q  <= s1_spec_q;
            s2_sign_q  <= s1_sign_q;
            s2_sval_q  <= s1_sval_q;
            s2_exp_q   <= s1_exp_q;
            s2_sum_q   <= s2_sum_d;
            s2_tag_q   <= s1_tag_q;
            out_valid  <= s2_v_q;
            out_result <= res_d;
            out_tag    <= s2_tag_q;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vectors, randomized streaming against an exact
// integer model, backpressure and mid-flight reset for fp_add_pipe.
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic [7:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [7:0]  out_tag;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp_add_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

`ifdef FP_ADD_RNE_EN
    localparam logic [31:0] RND_EXP = 32'h3F800001;
`else
    localparam logic [31:0] RND_EXP = 32'h3F800000;
`endif
    localparam int ND = 13;
    localparam logic [31:0] DA [ND] = '{
        32'h3F800000, 32'h3F800000, 32'h40000000, 32'h7F7FFFFF, 32'h7F800000,
        32'h7FC00001, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h00000000,
        32'hFF800000, 32'h00000000, 32'h7F800000};
    localparam logic [31:0] DB [ND] = '{
        32'h40000000, 32'h3F800000, 32'h40400000, 32'h7F7FFFFF, 32'hFF800000,
        32'h3F800000, 32'h33C00000, 32'h33800000, 32'h80000000, 32'h3F800000,
        32'h3F800000, 32'h80000000, 32'h7F800000};
    localparam logic DS [ND] = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    localparam logic [31:0] DE [ND] = '{
        32'h40400000, 32'h00000000, 32'hBF800000, 32'h7F800000, 32'h7FC00000,
        32'h7FC00000, RND_EXP,      32'h3F800000, 32'h80000000, 32'hBF800000,
        32'hFF800000, 32'h00000000, 32'h7FC00000};

    // Exact sum in wide integers, then rounded/truncated to single precision.
    function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b, logic sub);
        logic sa, sb, s;
        int ea, eb, emin, p, e;
        logic [299:0] A, B, mag, keep, rem, half;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0))
            return 32'h7FC00000;
        if (ea == 255 && eb == 255)
            return (sa != sb) ? 32'h7FC00000 : {sa, 8'hFF, 23'h0};
        if (ea == 255) return {sa, 8'hFF, 23'h0};
        if (eb == 255) return {sb, 8'hFF, 23'h0};
        if (ea == 0 && eb == 0) return {sa & sb, 31'h0};
        if (ea == 0) return {sb, b[30:0]};
        if (eb == 0) return a;
        emin = (ea < eb) ? ea : eb;
        A = 300'({1'b1, a[22:0]}) << (ea - emin);
        B = 300'({1'b1, b[22:0]}) << (eb - emin);
        if (sa == sb) begin mag = A + B; s = sa; end
        else if (A >= B) begin mag = A - B; s = sa; end
        else begin mag = B - A; s = sb; end
        if (mag == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = emin + p - 23;
        if (p > 23) begin
            keep = mag >> (p - 23);
            rem  = mag - (keep << (p - 23));
            half = 300'(1) << (p - 24);
        end else begin
            keep = mag << (23 - p);
            rem  = 0;
            half = 1;
        end
`ifdef FP_ADD_RNE_EN
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (keep[24]) begin keep = keep >> 1; e++; end
`endif
        if (rem == half && half == 0) e = e;
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, e[7:0], keep[22:0]};
    endfunction

    task automatic gen_op(input int e, output logic [31:0] v);
        v = {1'($urandom), 8'(e), 23'($urandom)};
    endtask

    task automatic gen_special(output logic [31:0] v);
        case ($urandom_range(0, 3))
            0: v = {1'($urandom), 31'h0};
            1: v = {1'($urandom), 8'hFF, 23'h0};
            2: v = {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7FFFFF))};
            default: v = {1'($urandom), 8'h00, 23'($urandom)};
        endcase
    endtask

    task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
        int r, ea, eb;
        r = int'($urandom_range(0, 99));
        if (r % 5 == 0)
            ea = ($urandom % 2 != 0) ? int'($urandom_range(250, 254)) : int'($urandom_range(1, 4));
        else
            ea = int'($urandom_range(1, 254));
        gen_op(ea, a);
        if (r < 8) gen_special(a);
        if (r >= 8 && r < 16) gen_special(b);
        else if (r < 40) b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 255))};
        else if (r < 50) gen_op(int'($urandom_range(1, 254)), b);
        else begin
            eb = ea + int'($urandom_range(0, 60)) - 30;
            if (eb < 1) eb = 1;
            if (eb > 254) eb = 254;
            gen_op(eb, b);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic [7:0] tag, output logic [31:0] res,
                        output logic [7:0] rt, output int lat);
        in_a = a; in_b = b; in_sub = sub; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_result;
        rt = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++;
        if (out_result !== 32'h0) begin failures++; $display("FAIL reset_result got %h want 0", out_result); end
        checks++;
        if (out_tag !== 8'h0) begin failures++; $display("FAIL reset_tag got %h want 0", out_tag); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] res;
        logic [7:0] rt;
        int lat;
        for (int i = 0; i < ND; i++) begin
            xfer(DA[i], DB[i], DS[i], 8'(i + 5), res, rt, lat);
            checks++;
            if (res !== DE[i]) begin
                failures++;
                $display("FAIL dir%0d_result got %h want %h", i, res, DE[i]);
            end
            checks++;
            if (rt !== 8'(i + 5)) begin
                failures++;
                $display("FAIL dir%0d_tag got %0d want %0d", i, rt, i + 5);
            end
            checks++;
            if (lat !== 3) begin
                failures++;
                $display("FAIL dir%0d_latency got %0d want 3", i, lat);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [39:0] q[$];
        logic [39:0] e;
        logic [31:0] a, b, r;
        logic [7:0] t;
        logic pend, acc_in, acc_out;
        int sent, recv, cyc;
        sent = 0; recv = 0; cyc = 0; pend = 1'b0;
        while (recv < n && cyc < 20000) begin
            if (!pend && sent < n && $urandom_range(0, 3) != 0) begin
                gen_pair(a, b);
                in_a = a; in_b = b; in_sub = 1'($urandom); in_tag = 8'($urandom);
                pend = 1'b1;
            end
            in_valid = pend;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc_in = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            r = out_result;
            t = out_tag;
            if (acc_in) q.push_back({in_tag, ref_add(in_a, in_b, in_sub)});
            @(posedge clk); #1;
            cyc++;
            if (acc_in) begin pend = 1'b0; sent++; end
            if (acc_out) begin
                recv++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious got tag %h result %h want none", t, r);
                end else begin
                    e = q.pop_front();
                    if ({t, r} !== e) begin
                        failures++;
                        $display("FAIL rnd_result got tag %h result %h want tag %h result %h",
                                 t, r, e[39:32], e[31:0]);
                    end
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (recv != n || q.size() != 0) begin
            failures++;
            $display("FAIL rnd_count got %0d want %0d (pending %0d)", recv, n, q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] pa [6];
        logic [31:0] pb [6];
        logic ps [6];
        logic [31:0] pe [6];
        logic [39:0] held;
        logic held_v, stall, acc_in, acc_out;
        int sent, recv, cyc, extra;
        for (int i = 0; i < 6; i++) begin
            gen_pair(pa[i], pb[i]);
            ps[i] = 1'($urandom);
            pe[i] = ref_add(pa[i], pb[i], ps[i]);
        end
        sent = 0; recv = 0; cyc = 0; held_v = 1'b0; stall = 1'b0; held = '0;
        while (recv < 6 && cyc < 100) begin
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_a = pa[sent]; in_b = pb[sent]; in_sub = ps[sent]; in_tag = 8'(sent);
            end
            out_ready = !(cyc >= 2 && cyc <= 6);
            #1;
            if (!in_ready) stall = 1'b1;
            if (held_v && out_valid) begin
                checks++;
                if ({out_tag, out_result} !== held) begin
                    failures++;
                    $display("FAIL bp_hold got %h want %h", {out_tag, out_result}, held);
                end
            end
            held_v = out_valid && !out_ready;
            held = {out_tag, out_result};
            acc_in = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                checks++;
                if (recv >= 6 || {out_tag, out_result} !== {8'(recv), pe[recv]}) begin
                    failures++;
                    $display("FAIL bp_result got tag %0d result %h want tag %0d result %h",
                             out_tag, out_result, recv, pe[recv % 6]);
                end
                recv++;
            end
            @(posedge clk); #1;
            if (acc_in) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        extra = 0;
        repeat (6) begin
            #1;
            if (out_valid) extra++;
            @(posedge clk); #1;
        end
        checks++;
        if (recv != 6 || extra != 0) begin
            failures++;
            $display("FAIL bp_count got %0d plus %0d extra want 6", recv, extra);
        end
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL bp_ready_drop got %b want 1", stall); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] res;
        logic [7:0] rt;
        int lat, seen;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0; in_tag = 8'(i + 40);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got %b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_clear got %b want 0", out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL mid_stale got %0d want 0", seen); end
        xfer(32'h40000000, 32'h40400000, 1'b1, 8'h77, res, rt, lat);
        checks++;
        if ({rt, res} !== {8'h77, 32'hBF800000}) begin
            failures++;
            $display("FAIL mid_after got %h want %h", {rt, res}, {8'h77, 32'hBF800000});
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(400);
        test_backpressure();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
